sudoku_io_ctrl: RTL and testbench

SUDOKU_IO_CTRL -- requirements
Module: sudoku_io_ctrl

---
 rtl/sudoku_io_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sudoku_io_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_io_ctrl.sv
// sudoku_io_ctrl: copies the puzzle from ROM into the working RAM, starts the
// solver engine, hands the RAM port to the engine while it runs, and flags
// completion once the engine reports the puzzle solved.
// Optional build macro BLANK_CNT_EN: count the blank (zero) cells while
// loading and skip the engine entirely when the puzzle has no blanks.
module sudoku_io_ctrl #(
    parameter int CELLS = 81,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    output logic          ROM_rd,
    output logic [6:0]    ROM_A,
    input  logic [DW-1:0] ROM_Q,
    output logic          RAM_ceb,
    output logic          RAM_web,
    output logic [6:0]    RAM_A,
    output logic [DW-1:0] RAM_D,
    input  logic [DW-1:0] RAM_Q,
    output logic          eng_start,
    input  logic          eng_done,
    input  logic          eng_ceb,
    input  logic          eng_web,
    input  logic [6:0]    eng_A,
    input  logic [DW-1:0] eng_D,
    output logic [DW-1:0] eng_Q,
    output logic [6:0]    blank_cnt,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        KICK  = 3'd2,
        SOLVE = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [6:0] LAST_ADDR = 7'(CELLS - 1);

    state_t        state_r;
    logic          rom_rd_r;
    logic [6:0]    rom_a_r;      // read pointer k; also drives ROM_A
    logic          wr_en_r;      // write stage active this cycle
    logic [6:0]    wr_a_r;       // address read one cycle earlier
    logic          eng_start_r;
    logic          done_r;
    logic [6:0]    blank_cnt_r;

    logic [6:0]    blank_next_s;
    logic          skip_solve_s;
    logic          ram_ceb_s;
    logic          ram_web_s;
    logic [6:0]    ram_a_s;
    logic [DW-1:0] ram_d_s;

`ifdef BLANK_CNT_EN
    logic blank_inc_s;
    // Count a blank whenever the cell being written this cycle is zero.
    assign blank_inc_s  = wr_en_r && (ROM_Q == {DW{1'b0}});
    assign blank_next_s = blank_inc_s ? (blank_cnt_r + 7'd1) : blank_cnt_r;
    // A puzzle with no blanks is already solved; no need to run the engine.
    assign skip_solve_s = (blank_next_s == 7'd0);
`else
    assign blank_next_s = 7'd0;
    assign skip_solve_s = 1'b0;
`endif

    // Main sequencer: load pipeline, engine kick, solve wait and completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            rom_rd_r    <= 1'b0;
            rom_a_r     <= 7'd0;
            wr_en_r     <= 1'b0;
            wr_a_r      <= 7'd0;
            eng_start_r <= 1'b0;
            done_r      <= 1'b0;
            blank_cnt_r <= 7'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r  <= LOAD;
                    rom_rd_r <= 1'b1;
                    rom_a_r  <= 7'd0;
                    wr_en_r  <= 1'b0;
                end
                LOAD: begin
                    blank_cnt_r <= blank_next_s;
                    if (rom_rd_r) begin
                        // Read k is outstanding: schedule its write next cycle.
                        wr_en_r <= 1'b1;
                        wr_a_r  <= rom_a_r;
                        if (rom_a_r == LAST_ADDR) begin
                            rom_rd_r <= 1'b0;
                        end else begin
                            rom_a_r <= rom_a_r + 7'd1;
                        end
                    end else begin
                        // Final cycle: last write drains, ROM_A holds.
                        wr_en_r <= 1'b0;
                        if (skip_solve_s) begin
                            state_r <= FIN;
                            done_r  <= 1'b1;
                        end else begin
                            state_r     <= KICK;
                            eng_start_r <= 1'b1;
                        end
                    end
                end
                KICK: begin
                    eng_start_r <= 1'b0;
                    state_r     <= SOLVE;
                end
                SOLVE: begin
                    if (eng_done) begin
                        state_r <= FIN;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= SOLVE;
                    end
                end
                FIN: begin
                    state_r <= FIN;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r     <= IDLE;
                    rom_rd_r    <= 1'b0;
                    wr_en_r     <= 1'b0;
                    eng_start_r <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    // RAM port mux: engine owns it in SOLVE, load writes own it otherwise.
    always_comb begin
        ram_ceb_s = 1'b1;
        ram_web_s = 1'b1;
        ram_a_s   = 7'd0;
        ram_d_s   = {DW{1'b0}};
        if (state_r == SOLVE) begin
            ram_ceb_s = eng_ceb;
            ram_web_s = eng_web;
            ram_a_s   = eng_A;
            ram_d_s   = eng_D;
        end else if (wr_en_r) begin
            ram_ceb_s = 1'b0;
            ram_web_s = 1'b0;
            ram_a_s   = wr_a_r;
            ram_d_s   = ROM_Q;
        end else begin
            ram_ceb_s = 1'b1;
            ram_web_s = 1'b1;
            ram_a_s   = 7'd0;
            ram_d_s   = {DW{1'b0}};
        end
    end

    assign ROM_rd    = rom_rd_r;
    assign ROM_A     = rom_a_r;
    assign RAM_ceb   = ram_ceb_s;
    assign RAM_web   = ram_web_s;
    assign RAM_A     = ram_a_s;
    assign RAM_D     = ram_d_s;
    assign eng_start = eng_start_r;
    assign eng_Q     = RAM_Q;
    assign blank_cnt = blank_cnt_r;
    assign done      = done_r;

endmodule

// File: tb/tb_sudoku_io_ctrl.sv
// Scoreboard bench for sudoku_io_ctrl: randomized puzzles, ROM/RAM/engine
// models, expected RAM writes and start/done events queued by the stimulus
// and consumed by an independent monitor.
module tb_sudoku_io_ctrl;

    localparam int CELLS = 81;
    localparam int DW    = 8;
    localparam int EV_WR    = 1;
    localparam int EV_START = 2;
    localparam int EV_DONE  = 3;

`ifdef BLANK_CNT_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ROM_rd;
    logic [6:0]    ROM_A;
    logic [DW-1:0] ROM_Q;
    logic          RAM_ceb;
    logic          RAM_web;
    logic [6:0]    RAM_A;
    logic [DW-1:0] RAM_D;
    logic [DW-1:0] RAM_Q;
    logic          eng_start;
    logic          eng_done = 1'b0;
    logic          eng_ceb  = 1'b1;
    logic          eng_web  = 1'b1;
    logic [6:0]    eng_A    = 7'd0;
    logic [DW-1:0] eng_D    = 8'd0;
    logic [DW-1:0] eng_Q;
    logic [6:0]    blank_cnt;
    logic          done;

    logic [7:0] rom [0:127];
    logic [7:0] ram [0:127];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    sudoku_io_ctrl #(.CELLS(CELLS), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .ROM_rd(ROM_rd), .ROM_A(ROM_A), .ROM_Q(ROM_Q),
        .RAM_ceb(RAM_ceb), .RAM_web(RAM_web), .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_Q(RAM_Q),
        .eng_start(eng_start), .eng_done(eng_done),
        .eng_ceb(eng_ceb), .eng_web(eng_web), .eng_A(eng_A), .eng_D(eng_D),
        .eng_Q(eng_Q), .blank_cnt(blank_cnt), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (ROM_rd) ROM_Q <= rom[ROM_A];
    end

    // Synchronous single-port RAM with active-low controls.
    always @(posedge clk) begin
        if (!RAM_ceb && !RAM_web) ram[RAM_A] <= RAM_D;
        else if (!RAM_ceb) RAM_Q <= ram[RAM_A];
    end

    function automatic int enc(input int kind, input int a, input int d);
        return (kind << 16) | (a << 8) | d;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic pop_check(input string name, input int act);
        int e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event 0x%0h, none expected at %0t", name, act, $time);
        end else begin
            e = exp_q.pop_front();
            if (e != act) begin
                n_fail++;
                $display("FAIL %s: got event 0x%0h expected 0x%0h at %0t", name, act, e, $time);
            end
        end
    endtask

    // Bounded wait: 0 = eng_start, 1 = done, other = scoreboard drained.
    task automatic wait_cond(input int which, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk); #1;
            case (which)
                0:       hit = eng_start;
                1:       hit = done;
                default: hit = (exp_q.size() == 0);
            endcase
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles", name, budget);
        end
    endtask

    // Reference puzzle: random digits 1..9 with exactly `zeros` blanks.
    task automatic make_puzzle(input int zeros);
        int placed = 0;
        for (int k = 0; k < 128; k++) rom[k] = 8'($urandom_range(1, 9));
        while (placed < zeros) begin
            int idx = $urandom_range(0, CELLS - 1);
            if (rom[idx] != 8'd0) begin
                rom[idx] = 8'd0;
                placed++;
            end
        end
    endtask

    function automatic int count_zeros();
        int n = 0;
        for (int k = 0; k < CELLS; k++) if (rom[k] == 8'd0) n++;
        return n;
    endfunction

    function automatic int exp_blank();
        return BLANK_EN ? count_zeros() : 0;
    endfunction

    task automatic clear_ram();
        for (int k = 0; k < 128; k++) ram[k] = 8'hEE;
    endtask

    // Expected events of one full load and what follows it.
    task automatic push_load();
        for (int k = 0; k < CELLS; k++) exp_q.push_back(enc(EV_WR, k, rom[k]));
        if (BLANK_EN && count_zeros() == 0) exp_q.push_back(enc(EV_DONE, 0, 0));
        else exp_q.push_back(enc(EV_START, 0, 0));
    endtask

    task automatic ram_check(input string name);
        int bad = 0;
        for (int k = 0; k < CELLS; k++) if (ram[k] !== rom[k]) bad++;
        check(name, bad, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_rd"}, ROM_rd, 0);
        check({tag, "_rom_a"}, ROM_A, 0);
        check({tag, "_ram_ceb"}, RAM_ceb, 1);
        check({tag, "_ram_web"}, RAM_web, 1);
        check({tag, "_ram_a"}, RAM_A, 0);
        check({tag, "_ram_d"}, RAM_D, 0);
        check({tag, "_eng_start"}, eng_start, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_blank_cnt"}, blank_cnt, 0);
    endtask

    // Monitor: compares every observed DUT event against the scoreboard.
    int  rd_exp     = 0;
    bit  prev_start = 1'b0;
    bit  prev_done  = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            rd_exp     = 0;
            prev_start = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (ROM_rd) begin
                check("rom_read_addr", ROM_A, rd_exp);
                rd_exp++;
            end
            if (!RAM_ceb && !RAM_web) pop_check("ram_write", enc(EV_WR, RAM_A, RAM_D));
            if (eng_start && !prev_start) pop_check("eng_start", enc(EV_START, 0, 0));
            if (prev_start) check("eng_start_width", eng_start, 0);
            if (done && !prev_done) pop_check("done_rise", enc(EV_DONE, 0, 0));
            if (prev_done) check("done_sticky", done, 1);
            check("eng_q_pass", eng_Q, RAM_Q);
            prev_start = eng_start;
            prev_done  = done;
        end
    end

    initial begin
        int bad;
        clear_ram();

        // Run A: 40 blanks, engine noise and eng_done held high during load.
        make_puzzle(40);
        #20;
        check_reset_outputs("por");
        push_load();
        eng_done = 1'b1; eng_ceb = 1'b0; eng_web = 1'b0; eng_A = 7'd3; eng_D = 8'hAA;
        #60;
        rst = 1'b0;
        wait_cond(0, 200, "start_a");
        eng_done = 1'b0; eng_ceb = 1'b1; eng_web = 1'b1; eng_A = 7'd0; eng_D = 8'd0;
        check("blank_a", blank_cnt, exp_blank());
        check("done_before_solve", done, 0);
        ram_check("load_a");
        @(posedge clk); #1;
        exp_q.push_back(enc(EV_WR, 7, 5));
        eng_ceb = 1'b0; eng_web = 1'b0; eng_A = 7'd7; eng_D = 8'h05;
        @(posedge clk); #1;
        eng_web = 1'b1;
        @(posedge clk); #1;
        check("eng_q_read7", eng_Q, 5);
        eng_ceb = 1'b1;
        exp_q.push_back(enc(EV_DONE, 0, 0));
        eng_done = 1'b1;
        @(posedge clk); #1;
        eng_done = 1'b0;
        check("done_a", done, 1);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (!done) bad++;
        end
        check("done_hold_100", bad, 0);
        check("ram7_engine", ram[7], 5);
        check("ram3_kept", ram[3], rom[3]);
        check("ram0_kept", ram[0], rom[0]);

        // Run B: reset in LOAD cycle 40, then a full reload and recount.
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_fin");
        make_puzzle($urandom_range(1, 60));
        clear_ram();
        for (int k = 0; k < 40; k++) exp_q.push_back(enc(EV_WR, k, rom[k]));
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        wait_cond(2, 200, "abort_point");
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(negedge clk);
        #1;
        clear_ram();
        push_load();
        rst = 1'b0;
        wait_cond(0, 200, "start_b");
        check("blank_b", blank_cnt, exp_blank());
        ram_check("load_b");
        @(posedge clk); #1;
        exp_q.push_back(enc(EV_DONE, 0, 0));
        eng_done = 1'b1;
        @(posedge clk); #1;
        eng_done = 1'b0;
        check("done_b", done, 1);

        // Run C: puzzle already solved (no blanks).
        @(negedge clk); #1;
        rst = 1'b1;
        make_puzzle(0);
        clear_ram();
        push_load();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
`ifdef BLANK_CNT_EN
        wait_cond(1, 200, "done_c");
        check("blank_c", blank_cnt, 0);
        ram_check("load_c");
`else
        wait_cond(0, 200, "start_c");
        check("blank_c", blank_cnt, 0);
        ram_check("load_c");
        repeat (5) @(posedge clk);
        #1;
        check("done_waits_engine", done, 0);
        exp_q.push_back(enc(EV_DONE, 0, 0));
        eng_done = 1'b1;
        @(posedge clk); #1;
        eng_done = 1'b0;
        check("done_c", done, 1);
`endif
        repeat (5) @(negedge clk);
        wait_cond(2, 10, "scoreboard_drain");
        check("leftover_events", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
